comparator_search_bdeduffy: RTL

Sequential binary-search companion to the 3-bit magnitude comparator. The block drives the comparator's `valB` input with successive guesses and reads back the comparator's flags (`aGTb`, `aLTb`, `aEQb`) to recover the unknown `valA`. It reports the recovered value, the number of probes used, and an error flag if the flag responses are inconsistent.

---
 rtl/comparator_search_bdeduffy.sv | 134 +++++++++++++
 1 files changed

// File: rtl/comparator_search_bdeduffy.sv
// Binary-search driver for a WIDTH-bit magnitude comparator: probes valB with
// successive guesses, reads back the flags and recovers the unknown valA.
module comparator_search_bdeduffy #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             aGTb,
  input  logic             aLTb,
  input  logic             aEQb,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       steps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } stateT;

  localparam logic [WIDTH-1:0] MAX_VAL     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FIRST_GUESS = MAX_VAL >> 1;
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  stateT            state, nextState;
  logic [WIDTH-1:0] lo, hi;
  logic [WIDTH-1:0] nextLo, nextHi, nextGuess, nextResult;
  logic [3:0]       nextSteps;

  logic flagsValid;
  logic atHi, atLo;
  logic rangeExhausted;
  logic acceptStart;

  // The comparator must answer with exactly one flag per probe.
  always_comb begin
    flagsValid = 1'b0;
    case ({aGTb, aLTb, aEQb})
      3'b100, 3'b010, 3'b001: flagsValid = 1'b1;
      default:                flagsValid = 1'b0;
    endcase
  end

  assign atHi           = (guess == hi);
  assign atLo           = (guess == lo);
  assign rangeExhausted = (aGTb && atHi) || (aLTb && atLo);
  assign acceptStart    = start && (state != PROBE);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) nextState = PROBE;
      end
      PROBE: begin
        if (!flagsValid || rangeExhausted) nextState = ERROR;
        else if (aEQb)                     nextState = DONE;
        else                               nextState = PROBE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath next values: range narrowing, probe count and captured result.
  always_comb begin
    nextLo     = lo;
    nextHi     = hi;
    nextGuess  = guess;
    nextResult = result;
    nextSteps  = steps;
    if (acceptStart) begin
      nextLo    = '0;
      nextHi    = MAX_VAL;
      nextGuess = FIRST_GUESS;
      nextSteps = 4'd0;
    end else if (state == PROBE) begin
      nextSteps = steps + 4'd1;
      if (flagsValid && !rangeExhausted) begin
        if (aEQb) begin
          nextResult = guess;
        end else begin
          if (aGTb) nextLo = guess + ONE;
          else      nextHi = guess - ONE;
          // lo <= hi always holds here, so the difference cannot wrap.
          nextGuess = nextLo + ((nextHi - nextLo) >> 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      steps  <= 4'd0;
    end else begin
      lo     <= nextLo;
      hi     <= nextHi;
      guess  <= nextGuess;
      result <= nextResult;
      steps  <= nextSteps;
    end
  end

  // Status levels follow the state directly, so they change on the same edge.
  always_comb begin
    busy  = (state == PROBE);
    done  = (state == DONE);
    error = (state == ERROR);
  end

endmodule
